// File: rtl/cb_douta_router.sv
// cb_douta_router: two-stage router of CB port-A read lanes to the A, B, M
// and TB consumers, with lane rotation, reversal, pair pick and TB staircase.
module cb_douta_router #(
   parameter int X               = 4,
   parameter int Y               = 4,
   parameter int L               = 4,
   parameter int RSA_DW          = 32,
   parameter int CB_DOUTA_SEL_DW = 5,
   parameter int ROT_DW          = 2,
   parameter int SEQ_DW          = 4
) (
   input  logic                         clk,
   input  logic                         sys_rst,
   input  logic                         CB_douta_vld,
   input  logic [CB_DOUTA_SEL_DW-1:0]   CB_douta_sel,
   input  logic [ROT_DW-1:0]            rot_ofs,
   input  logic                         l_k_0,
   input  logic signed [L*RSA_DW-1:0]   CB_douta,
   output logic signed [X*RSA_DW-1:0]   A_CB_douta,
   output logic                         A_vld,
   output logic signed [Y*RSA_DW-1:0]   B_CB_douta,
   output logic                         B_vld,
   output logic signed [X*RSA_DW-1:0]   M_CB_douta,
   output logic                         M_vld,
   output logic signed [X*RSA_DW-1:0]   TB_dina_CB_douta,
   output logic                         TB_vld,
   output logic                         tb_seq_done
);

   localparam int MW = (X > Y) ? X : Y;
   localparam logic [SEQ_DW-1:0] LAST_BEAT = SEQ_DW'(L);

   localparam logic [2:0] D_A  = 3'b001;
   localparam logic [2:0] D_B  = 3'b010;
   localparam logic [2:0] D_M  = 3'b011;
   localparam logic [2:0] D_TB = 3'b100;

   localparam logic [1:0] DIR_IDLE = 2'b00;
   localparam logic [1:0] DIR_POS  = 2'b01;
   localparam logic [1:0] DIR_NEG  = 2'b10;
   localparam logic [1:0] DIR_NEW  = 2'b11;

   logic [2:0]        in_dest;
   logic [1:0]        in_dir;
   logic              tb_new_in;
   logic [SEQ_DW-1:0] beat;

   logic              s1_vld;
   logic [2:0]        s1_dest;
   logic [1:0]        s1_dir;
   logic [ROT_DW-1:0] s1_rot;
   logic              s1_lk0;
   logic [SEQ_DW-1:0] s1_beat;
   logic              s1_done;
   logic [RSA_DW-1:0] s1_lane [L];

   logic [RSA_DW-1:0] e0;
   logic [RSA_DW-1:0] e1;
   logic [RSA_DW-1:0] perm [MW];
   logic [X*RSA_DW-1:0] pack_x;
   logic [Y*RSA_DW-1:0] pack_y;
   logic              sel_a;
   logic              sel_b;
   logic              sel_m;
   logic              sel_tb;

   assign in_dest   = CB_douta_sel[4:2];
   assign in_dir    = CB_douta_sel[1:0];
   assign tb_new_in = CB_douta_vld && (in_dest == D_TB) && (in_dir == DIR_NEW);

   // Staircase beat index; any other accepted select aborts the sequence.
   always_ff @(posedge clk) begin
      if (sys_rst) begin
         beat <= '0;
      end else if (CB_douta_vld) begin
         if (tb_new_in)
            beat <= (beat == LAST_BEAT) ? '0 : beat + SEQ_DW'(1);
         else
            beat <= '0;
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         s1_vld  <= 1'b0;
         s1_dest <= '0;
         s1_dir  <= '0;
         s1_rot  <= '0;
         s1_lk0  <= 1'b0;
         s1_beat <= '0;
         s1_done <= 1'b0;
         for (int i = 0; i < L; i++)
            s1_lane[i] <= '0;
      end else begin
         s1_vld  <= CB_douta_vld;
         s1_dest <= in_dest;
         s1_dir  <= in_dir;
         s1_rot  <= rot_ofs;
         s1_lk0  <= l_k_0;
         s1_beat <= beat;
         s1_done <= tb_new_in && (beat == LAST_BEAT);
         for (int i = 0; i < L; i++)
            s1_lane[i] <= CB_douta[i*RSA_DW +: RSA_DW];
      end
   end

   always_comb begin
      int base;
      int j;
      base = s1_lk0 ? 0 : L/2;
      j    = int'(s1_beat);
      e0   = '0;
      e1   = '0;
      for (int k = 0; k < L; k++) begin
         if (k == base)
            e0 = s1_lane[k];
         if (k == base + 1)
            e1 = s1_lane[k];
      end
      for (int i = 0; i < MW; i++) begin
         perm[i] = '0;
         if (i < L) begin
            case (s1_dir)
               DIR_POS: begin
                  for (int k = 0; k < L; k++)
                     if (k == (i + int'(s1_rot)) % L)
                        perm[i] = s1_lane[k];
               end
               DIR_NEG: begin
                  for (int k = 0; k < L; k++)
                     if (k == L - 1 - i)
                        perm[i] = s1_lane[k];
               end
               DIR_NEW: begin
                  if (s1_dest == D_TB) begin
                     if (j == 0 && i == X - 1)
                        perm[i] = e1;
                     if (j >= 1 && i == j - 1)
                        perm[i] = e0;
                     if (j >= 2 && i == j - 2)
                        perm[i] = e1;
                  end else if (i == 0) begin
                     perm[i] = e0;
                  end else if (i == 1) begin
                     perm[i] = e1;
                  end
               end
               default: perm[i] = '0;
            endcase
         end
      end
   end

   always_comb begin
      pack_x = '0;
      pack_y = '0;
      for (int i = 0; i < X; i++)
         pack_x[i*RSA_DW +: RSA_DW] = perm[i];
      for (int i = 0; i < Y; i++)
         pack_y[i*RSA_DW +: RSA_DW] = perm[i];
   end

   assign sel_a  = s1_vld && (s1_dest == D_A);
   assign sel_b  = s1_vld && (s1_dest == D_B);
   assign sel_m  = s1_vld && (s1_dest == D_M);
   assign sel_tb = s1_vld && (s1_dest == D_TB);

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         A_CB_douta       <= '0;
         A_vld            <= 1'b0;
         B_CB_douta       <= '0;
         B_vld            <= 1'b0;
         M_CB_douta       <= '0;
         M_vld            <= 1'b0;
         TB_dina_CB_douta <= '0;
         TB_vld           <= 1'b0;
         tb_seq_done      <= 1'b0;
      end else begin
         A_CB_douta       <= sel_a  ? pack_x : '0;
         A_vld            <= sel_a;
         B_CB_douta       <= sel_b  ? pack_y : '0;
         B_vld            <= sel_b;
         M_CB_douta       <= sel_m  ? pack_x : '0;
         M_vld            <= sel_m;
         TB_dina_CB_douta <= sel_tb ? pack_x : '0;
         TB_vld           <= sel_tb;
         tb_seq_done      <= s1_done;
      end
   end

endmodule

// File: tb/tb_cb_douta_router.sv
// tb_cb_douta_router: directed plus random stimulus against a lane-level
// reference model of the router, checked two cycles after each input.
module tb_cb_douta_router;

   localparam int X  = 4;
   localparam int Y  = 4;
   localparam int L  = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          sys_rst;
   logic          vld;
   logic [4:0]    sel;
   logic [1:0]    rot;
   logic          lk0;
   logic [127:0]  din;
   logic [127:0]  a_d, b_d, m_d, t_d;
   logic          a_v, b_v, m_v, t_v, done;

   always #5 clk = ~clk;

   cb_douta_router dut (
      .clk              (clk),
      .sys_rst          (sys_rst),
      .CB_douta_vld     (vld),
      .CB_douta_sel     (sel),
      .rot_ofs          (rot),
      .l_k_0            (lk0),
      .CB_douta         (din),
      .A_CB_douta       (a_d),
      .A_vld            (a_v),
      .B_CB_douta       (b_d),
      .B_vld            (b_v),
      .M_CB_douta       (m_d),
      .M_vld            (m_v),
      .TB_dina_CB_douta (t_d),
      .TB_vld           (t_v),
      .tb_seq_done      (done)
   );

   typedef struct {
      logic [127:0] a, b, m, t;
      logic         av, bv, mv, tv, dn;
   } exp_t;

   exp_t pend, cur, zero_e;
   int   beat;
   int   passed;
   int   fails;
   int   total;

   task automatic chk(string tag, logic [128:0] obs, logic [128:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // Reference: per-lane source choice from the routing rules, then the beat
   // bookkeeping of the TB staircase.
   function automatic exp_t model();
      exp_t        e;
      logic [31:0] il [4];
      logic [31:0] o  [4];
      logic [127:0] pk;
      int          dest, dir, b;
      bit          tbnew;
      e = zero_e;
      dest = int'(sel[4:2]);
      dir  = int'(sel[1:0]);
      for (int i = 0; i < L; i++) begin
         il[i] = din[i*DW +: DW];
         o[i]  = '0;
      end
      if (!vld) return e;
      tbnew = (dest == 4) && (dir == 3);
      b = lk0 ? 0 : L/2;
      case (dir)
         1: for (int i = 0; i < L; i++) o[i] = il[(i + int'(rot)) % L];
         2: for (int i = 0; i < L; i++) o[i] = il[L-1-i];
         3: begin
            if (dest == 4) begin
               if (beat == 0) o[X-1] = il[b+1];
               else begin
                  o[beat-1] = il[b];
                  if (beat >= 2) o[beat-2] = il[b+1];
               end
            end else begin
               o[0] = il[b];
               o[1] = il[b+1];
            end
         end
         default: ;
      endcase
      pk = {o[3], o[2], o[1], o[0]};
      case (dest)
         1: begin e.a = pk; e.av = 1'b1; end
         2: begin e.b = pk; e.bv = 1'b1; end
         3: begin e.m = pk; e.mv = 1'b1; end
         4: begin e.t = pk; e.tv = 1'b1; e.dn = tbnew && (beat == L); end
         default: ;
      endcase
      if (tbnew) beat = (beat == L) ? 0 : beat + 1;
      else beat = 0;
      return e;
   endfunction

   task automatic tick(string tag);
      exp_t n;
      if (sys_rst) begin
         n = zero_e;
         beat = 0;
      end else begin
         n = model();
      end
      @(posedge clk);
      #1;
      if (sys_rst) begin
         cur  = zero_e;
         pend = zero_e;
      end else begin
         cur  = pend;
         pend = n;
      end
      chk({tag, ".A"},  {a_v, a_d}, {cur.av, cur.a});
      chk({tag, ".B"},  {b_v, b_d}, {cur.bv, cur.b});
      chk({tag, ".M"},  {m_v, m_d}, {cur.mv, cur.m});
      chk({tag, ".TB"}, {t_v, t_d}, {cur.tv, cur.t});
      chk({tag, ".done"}, {128'd0, done}, {128'd0, cur.dn});
   endtask

   task automatic drive(bit v, logic [4:0] s, int r, bit k,
                        logic [127:0] d, string tag);
      vld = v;
      sel = s;
      rot = r[1:0];
      lk0 = k;
      din = d;
      tick(tag);
   endtask

   task automatic idle(string tag);
      drive(1'b0, 5'd0, 0, 1'b0, 128'd0, tag);
   endtask

   localparam logic [4:0] A_POS  = 5'b001_01;
   localparam logic [4:0] B_POS  = 5'b010_01;
   localparam logic [4:0] B_NEG  = 5'b010_10;
   localparam logic [4:0] M_NEW  = 5'b011_11;
   localparam logic [4:0] TB_NEW = 5'b100_11;

   initial begin
      logic [127:0] abcd;
      logic [127:0] seq10;
      logic [127:0] seq5;
      logic [127:0] r;
      int           sc;
      passed = 0;
      fails  = 0;
      total  = 0;
      beat   = 0;
      zero_e = '{a: '0, b: '0, m: '0, t: '0,
                 av: 1'b0, bv: 1'b0, mv: 1'b0, tv: 1'b0, dn: 1'b0};
      pend = zero_e;
      cur  = zero_e;
      abcd  = {32'd4, 32'd3, 32'd2, 32'd1};
      seq10 = {32'd13, 32'd12, 32'd11, 32'd10};
      seq5  = {32'd8, 32'd7, 32'd6, 32'd5};

      sys_rst = 1'b1;
      idle("rst0");
      idle("rst1");
      sys_rst = 1'b0;
      idle("post_rst");

      drive(1'b1, A_POS, 0, 1'b0, abcd, "a_pos");
      idle("a_pos_out");
      chk("a_lit", {a_v, a_d}, {1'b1, abcd});
      chk("a_tb_off", {t_v, t_d}, 129'd0);

      drive(1'b1, B_POS, 1, 1'b0, seq10, "b_pos");
      drive(1'b1, B_NEG, 3, 1'b0, seq10, "b_neg");
      chk("b_rot_lit", {b_v, b_d}, {1'b1, 32'd10, 32'd13, 32'd12, 32'd11});
      idle("b_neg_out");
      chk("b_neg_lit", {b_v, b_d}, {1'b1, 32'd10, 32'd11, 32'd12, 32'd13});

      drive(1'b1, M_NEW, 0, 1'b1, seq5, "m_new1");
      drive(1'b1, M_NEW, 0, 1'b0, seq5, "m_new0");
      chk("m_lk1_lit", {m_v, m_d}, {1'b1, 32'd0, 32'd0, 32'd6, 32'd5});
      idle("m_new0_out");
      chk("m_lk0_lit", {m_v, m_d}, {1'b1, 32'd0, 32'd0, 32'd8, 32'd7});

      for (int j = 0; j < 5; j++)
         drive(1'b1, TB_NEW, 0, 1'b0, abcd, "tb_seq");
      idle("tb_seq_out");
      chk("tb_b4_lit", {t_v, t_d}, {1'b1, 32'd3, 32'd4, 32'd0, 32'd0});
      chk("tb_b4_done", {128'd0, done}, {128'd0, 1'b1});
      idle("tb_seq_after");

      for (int j = 0; j < 3; j++)
         drive(1'b1, TB_NEW, 0, 1'b0, abcd, "gap_pre");
      idle("gap");
      drive(1'b1, TB_NEW, 0, 1'b0, abcd, "gap_b3");
      idle("gap_b3_out");
      chk("gap_b3_lit", {t_v, t_d}, {1'b1, 32'd0, 32'd3, 32'd4, 32'd0});
      drive(1'b1, TB_NEW, 0, 1'b0, abcd, "gap_b4");

      for (int j = 0; j < 3; j++)
         drive(1'b1, TB_NEW, 0, 1'b0, abcd, "clr_pre");
      drive(1'b1, A_POS, 2, 1'b0, abcd, "clr_a");
      drive(1'b1, TB_NEW, 0, 1'b0, abcd, "clr_b0");
      idle("clr_b0_out");
      chk("clr_b0_lit", {t_v, t_d}, {1'b1, 32'd4, 32'd0, 32'd0, 32'd0});

      for (int j = 0; j < 4; j++)
         drive(1'b1, TB_NEW, 0, 1'b1, abcd, "rst_pre");
      sys_rst = 1'b1;
      drive(1'b1, TB_NEW, 0, 1'b1, abcd, "mid_rst");
      chk("mid_rst_lit", {t_v, t_d, done}, 130'd0);
      sys_rst = 1'b0;
      for (int j = 0; j < 5; j++)
         drive(1'b1, TB_NEW, 0, 1'b1, abcd, "rst_seq");
      drive(1'b1, 5'b111_01, 0, 1'b0, abcd, "dest7");
      idle("dest7_out");
      chk("dest7_lit", {a_v, b_v, m_v, t_v}, 4'b0000);

      for (int n = 0; n < 500; n++) begin
         r = {$urandom, $urandom, $urandom, $urandom};
         sc = $urandom_range(0, 99);
         sys_rst = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 99) < 85,
               (sc < 50) ? TB_NEW : 5'($urandom),
               int'($urandom_range(0, 3)), 1'($urandom), r, "rand");
      end
      sys_rst = 1'b0;
      idle("drain0");
      idle("drain1");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
